// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------------------------
// phase_sequencer
//
// Multi-phase instruction sequencer for the 16-bit core. Every instruction is stepped through
// P1 fetch, P2 decode, P3 execute, P4 memory (loads/stores only) and P5 writeback. The block
// owns run/stop control, recognises the halt instruction, stretches P1/P4 across memory wait
// states and counts retired instructions.
//
// Parameters:
//   HLT_FCODE  function code that halts the core when the instruction class is 2'b11
//   CNT_W      width of the retired-instruction counter
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      single-cycle pulse; leave HALT and begin fetching
//   stop       single-cycle pulse; halt at the next instruction boundary
//   in_class   instruction bits [15:14] (11 ALU, 00 LD, 01 ST, 10 immediate/branch)
//   in_fcode   decoded function code from the decode register
//   br_taken   branch condition result, valid in P5
//   mem_ready  memory completes the current access this cycle
//   phase      one-hot phase, bit0 = P1 ... bit4 = P5; all zero in HALT
//   ld_ir      load instruction register
//   ld_rf      load strobe to the instruction-field decode register
//   pc_inc     PC += 1
//   pc_ld      PC <= branch target
//   alu_en     execute-stage enable
//   mem_rd     memory read request
//   mem_wr     memory write request
//   reg_we     register-file write enable
//   halted     sequencer is in HALT
//   icount     retired-instruction count (wraps)
// ---------------------------------------------------------------------------------------------
module phase_sequencer #(
   parameter logic [3:0]  HLT_FCODE = 4'b1111,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       in_class,
   input  logic [3:0]       in_fcode,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic [4:0]       phase,
   output logic             ld_ir,
   output logic             ld_rf,
   output logic             pc_inc,
   output logic             pc_ld,
   output logic             alu_en,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             reg_we,
   output logic             halted,
   output logic [CNT_W-1:0] icount
);

   localparam logic [1:0] ClsLd  = 2'b00;
   localparam logic [1:0] ClsSt  = 2'b01;
   localparam logic [1:0] ClsBr  = 2'b10;
   localparam logic [1:0] ClsAlu = 2'b11;

   typedef enum logic [2:0] {
      StHalt = 3'd0,
      StP1   = 3'd1,
      StP2   = 3'd2,
      StP3   = 3'd3,
      StP4   = 3'd4,
      StP5   = 3'd5
   } state_e;

   state_e           state_q;
   logic             stop_pend_q;
   logic [CNT_W-1:0] icount_q;

   logic is_hlt_instr;
   logic is_mem_instr;

   assign is_hlt_instr = (in_class == ClsAlu) && (in_fcode == HLT_FCODE);
   assign is_mem_instr = (in_class == ClsLd) || (in_class == ClsSt);

   // ------------------------------------------------------------------------------------------
   // State, sticky stop request and retired-instruction counter
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHalt;
         stop_pend_q <= 1'b0;
         icount_q    <= '0;
      end else begin
         // A stop while running is remembered until the instruction boundary; the per-state
         // assignments below take precedence where the request is consumed.
         if ((state_q != StHalt) && stop) begin
            stop_pend_q <= 1'b1;
         end

         case (state_q)
            StHalt: begin
               stop_pend_q <= 1'b0;
               // Simultaneous start and stop resolves in favour of staying halted.
               if (start && !stop) begin
                  state_q <= StP1;
               end
            end

            StP1: begin
               if (mem_ready) begin
                  state_q <= StP2;
               end
            end

            StP2: begin
               state_q <= StP3;
            end

            StP3: begin
               // The halt instruction never reaches writeback, so it is not counted.
               if (is_hlt_instr) begin
                  state_q <= StHalt;
               end else if (is_mem_instr) begin
                  state_q <= StP4;
               end else begin
                  state_q <= StP5;
               end
            end

            StP4: begin
               if (mem_ready) begin
                  state_q <= StP5;
               end
            end

            StP5: begin
               icount_q <= icount_q + 1'b1;
               if (stop_pend_q || stop) begin
                  state_q     <= StHalt;
                  stop_pend_q <= 1'b0;
               end else begin
                  state_q <= StP1;
               end
            end

            default: begin
               state_q <= StHalt;
            end
         endcase
      end
   end

   assign icount = icount_q;

   // ------------------------------------------------------------------------------------------
   // Strobe decode. Strobes are combinational so that fetch and memory handshakes react to
   // mem_ready in the same cycle, and so that reset drops every strobe immediately.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      phase  = 5'b00000;
      ld_ir  = 1'b0;
      ld_rf  = 1'b0;
      pc_inc = 1'b0;
      pc_ld  = 1'b0;
      alu_en = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      reg_we = 1'b0;
      halted = 1'b0;

      case (state_q)
         StHalt: begin
            halted = 1'b1;
         end

         StP1: begin
            phase  = 5'b00001;
            mem_rd = 1'b1;
            // The fetch completes only on the ready cycle, so IR load and PC bump happen once.
            ld_ir  = mem_ready;
            pc_inc = mem_ready;
         end

         StP2: begin
            phase = 5'b00010;
            ld_rf = 1'b1;
         end

         StP3: begin
            phase  = 5'b00100;
            alu_en = 1'b1;
         end

         StP4: begin
            phase  = 5'b01000;
            mem_rd = (in_class == ClsLd);
            mem_wr = (in_class == ClsSt);
         end

         StP5: begin
            phase  = 5'b10000;
            reg_we = (in_class == ClsAlu) || (in_class == ClsLd);
            pc_ld  = (in_class == ClsBr) && br_taken;
         end

         default: begin
            halted = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------------------------------
   a_phase_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(phase));
   a_mem_excl      : assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));
   a_halt_no_phase : assert property (@(posedge clk) disable iff (rst) halted == (phase == 5'b0));

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_phase_sequencer
//
// Drives whole instructions into phase_sequencer and checks every cycle against an
// instruction-level model: each instruction (class, fcode, branch outcome, fetch/memory wait
// counts, optional stop pulse) is expanded into the list of cycles it should occupy and the
// strobes each cycle should show. The counter is narrowed so that wrap-around is reachable.
// ---------------------------------------------------------------------------------------------
module tb_phase_sequencer;

   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [1:0]    in_class;
   logic [3:0]    in_fcode;
   logic          br_taken;
   logic          mem_ready;
   logic [4:0]    phase;
   logic          ld_ir;
   logic          ld_rf;
   logic          pc_inc;
   logic          pc_ld;
   logic          alu_en;
   logic          mem_rd;
   logic          mem_wr;
   logic          reg_we;
   logic          halted;
   logic [CW-1:0] icount;

   phase_sequencer #(
      .HLT_FCODE (4'b1111),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .in_class  (in_class),
      .in_fcode  (in_fcode),
      .br_taken  (br_taken),
      .mem_ready (mem_ready),
      .phase     (phase),
      .ld_ir     (ld_ir),
      .ld_rf     (ld_rf),
      .pc_inc    (pc_inc),
      .pc_ld     (pc_ld),
      .alu_en    (alu_en),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .reg_we    (reg_we),
      .halted    (halted),
      .icount    (icount)
   );

   always #5 clk = ~clk;

   typedef logic [13:0] ovec_t;

   ovec_t obs;
   assign obs = {phase, ld_ir, ld_rf, pc_inc, pc_ld, alu_en, mem_rd, mem_wr, reg_we, halted};

   int            total = 0;
   int            bad   = 0;
   logic [CW-1:0] m_count = '0;
   bit            m_halt  = 1'b1;

   // Expected output vector; ph = 0 means HALT, 1..5 means P1..P5.
   function automatic ovec_t ev(int ph, bit ir, bit rf, bit inc, bit pld, bit alu, bit rd,
                                bit wr, bit we);
      ovec_t v;
      logic [4:0] one;
      v   = '0;
      one = 5'b00001;
      if (ph > 0) v[13:9] = one << (ph - 1);
      v[8] = ir;
      v[7] = rf;
      v[6] = inc;
      v[5] = pld;
      v[4] = alu;
      v[3] = rd;
      v[2] = wr;
      v[1] = we;
      v[0] = (ph == 0);
      return v;
   endfunction

   task automatic check_now(string tag, ovec_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
      end
      total++;
      assert (icount === m_count) else begin
         bad++;
         $error("FAIL %s_icount observed=%0d expected=%0d", tag, icount, m_count);
      end
   endtask

   // One clock cycle: inputs are applied just after the rising edge, outputs are checked at
   // the falling edge.
   task automatic step(string tag, bit mr, bit st, bit sp, ovec_t exp);
      mem_ready = mr;
      start     = st;
      stop      = sp;
      @(negedge clk);
      check_now(tag, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_fields();
      in_class = 2'($urandom);
      in_fcode = 4'($urandom);
      br_taken = 1'($urandom);
   endtask

   task automatic idle(string tag, bit st, bit sp);
      scramble_fields();
      step(tag, 1'($urandom), st, sp, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (st && !sp) m_halt = 1'b0;
   endtask

   // Runs one instruction starting from its first P1 cycle. stop_ph selects the phase (1..5)
   // whose first cycle carries a stop pulse, 0 for none.
   task automatic run_instr(logic [1:0] c, logic [3:0] f, bit b, int w1, int w4, int stop_ph);
      bit hlt;
      bit stopped;
      bit sp;
      hlt     = (c == 2'b11) && (f == 4'b1111);
      stopped = 1'b0;

      for (int i = 0; i < w1; i++) begin
         scramble_fields();
         sp = (stop_ph == 1) && (i == 0);
         stopped |= sp;
         step("p1_wait", 1'b0, 1'($urandom), sp, ev(1, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      scramble_fields();
      sp = (stop_ph == 1) && (w1 == 0);
      stopped |= sp;
      step("p1_fetch", 1'b1, 1'($urandom), sp, ev(1, 1, 0, 1, 0, 0, 1, 0, 0));

      scramble_fields();
      sp = (stop_ph == 2);
      stopped |= sp;
      step("p2_decode", 1'($urandom), 1'($urandom), sp, ev(2, 0, 1, 0, 0, 0, 0, 0, 0));

      in_class = c;
      in_fcode = f;
      br_taken = 1'($urandom);
      sp = (stop_ph == 3);
      stopped |= sp;
      step("p3_exec", 1'($urandom), 1'($urandom), sp, ev(3, 0, 0, 0, 0, 1, 0, 0, 0));

      if (hlt) begin
         m_halt = 1'b1;
         return;
      end

      if (c[1] == 1'b0) begin
         for (int i = 0; i < w4; i++) begin
            br_taken = 1'($urandom);
            sp = (stop_ph == 4) && (i == 0);
            stopped |= sp;
            step("p4_wait", 1'b0, 1'($urandom), sp, ev(4, 0, 0, 0, 0, 0, c == 2'b00, c == 2'b01, 0));
         end
         br_taken = 1'($urandom);
         sp = (stop_ph == 4) && (w4 == 0);
         stopped |= sp;
         step("p4_mem", 1'b1, 1'($urandom), sp, ev(4, 0, 0, 0, 0, 0, c == 2'b00, c == 2'b01, 0));
      end

      br_taken = b;
      sp = (stop_ph == 5);
      stopped |= sp;
      step("p5_wb", 1'($urandom), 1'($urandom), sp,
           ev(5, 0, 0, 0, (c == 2'b10) && b, 0, 0, 0, (c == 2'b11) || (c == 2'b00)));
      m_count = m_count + 1'b1;
      m_halt  = stopped;
   endtask

   // Runs an instruction up to its first P4 cycle and asserts reset in the middle of it.
   task automatic reset_in_p4(logic [1:0] c);
      in_class = c;
      in_fcode = 4'h0;
      step("rp_p1", 1'b1, 1'b0, 1'b0, ev(1, 1, 0, 1, 0, 0, 1, 0, 0));
      step("rp_p2", 1'b1, 1'b0, 1'b0, ev(2, 0, 1, 0, 0, 0, 0, 0, 0));
      step("rp_p3", 1'b0, 1'b0, 1'b0, ev(3, 0, 0, 0, 0, 1, 0, 0, 0));
      mem_ready = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      @(negedge clk);
      check_now("rp_p4", ev(4, 0, 0, 0, 0, 0, c == 2'b00, c == 2'b01, 0));
      #1 rst = 1'b1;
      m_count = '0;
      m_halt  = 1'b1;
      #1;
      check_now("rp_async_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      in_class  = 2'b00;
      in_fcode  = 4'h0;
      br_taken  = 1'b0;
      mem_ready = 1'b0;
      #12;
      check_now("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;

      idle("halt_idle", 1'b0, 1'b0);
      idle("start", 1'b1, 1'b0);

      // Directed instruction mix
      run_instr(2'b11, 4'h0, 1'b0, 0, 0, 0);  // ALU
      run_instr(2'b00, 4'h3, 1'b0, 2, 3, 0);  // LD with wait states
      run_instr(2'b01, 4'h5, 1'b1, 0, 1, 0);  // ST
      run_instr(2'b10, 4'hF, 1'b1, 0, 0, 0);  // branch taken
      run_instr(2'b10, 4'h2, 1'b0, 1, 0, 0);  // branch not taken
      run_instr(2'b11, 4'hF, 1'b0, 0, 0, 0);  // halt instruction
      idle("after_hlt", 1'b0, 1'b0);
      idle("restart", 1'b1, 1'b0);
      run_instr(2'b11, 4'h7, 1'b0, 0, 0, 2);  // stop during P2
      idle("after_stop", 1'b0, 1'b0);
      idle("start_and_stop", 1'b1, 1'b1);
      idle("still_halted", 1'b0, 1'b0);
      idle("restart2", 1'b1, 1'b0);
      run_instr(2'b00, 4'h1, 1'b0, 0, 2, 5);  // stop in P5 itself
      idle("after_p5_stop", 1'b0, 1'b0);

      // Randomised instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [1:0] c;
         logic [3:0] f;
         int         sph;
         if (m_halt) begin
            idle("rnd_idle", 1'b0, 1'($urandom));
            idle("rnd_start", 1'b1, 1'b0);
         end
         c   = 2'($urandom);
         f   = 4'($urandom);
         if ((c == 2'b11) && (f == 4'hF) && ($urandom_range(0, 3) != 0)) f = 4'hE;
         sph = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
         run_instr(c, f, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), sph);
      end

      // Counter wrap
      if (m_halt) idle("wrap_start", 1'b1, 1'b0);
      while (m_count != {CW{1'b1}}) run_instr(2'b11, 4'h0, 1'b0, 0, 0, 0);
      run_instr(2'b11, 4'h0, 1'b0, 0, 0, 0);
      total++;
      assert (icount === {CW{1'b0}}) else begin
         bad++;
         $error("FAIL icount_wrap observed=%0d expected=0", icount);
      end

      // Reset in the memory phase of a load and of a store
      reset_in_p4(2'b00);
      idle("rst_ld_halt", 1'b1, 1'b0);
      reset_in_p4(2'b01);
      idle("rst_st_halt", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-phase instruction sequencer for the 16-bit processor core.
- Steps each instruction through P1 fetch, P2 decode, P3 execute, P4 memory and P5 writeback.
- Drives the load strobe of the instruction-field decode register and the PC, memory and register-file enables.
- Handles run/stop control, the halt instruction and memory wait states, and counts retired instructions.

Parameters:
- HLT_FCODE, 4'b1111, function code that halts the core when the instruction class is 2'b11.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse; leave HALT and begin fetching
- stop  input  1  single-cycle pulse; halt at the next instruction boundary
- in_class  input  2  instruction bits [15:14] of the current instruction word (11 ALU, 00 LD, 01 ST, 10 immediate/branch)
- in_fcode  input  4  decoded function code from the decode register
- br_taken  input  1  branch condition result, valid in P5
- mem_ready  input  1  memory completes the current access this cycle
- phase  output  5  one-hot phase: bit0 P1 … bit4 P5; 0 in HALT
- ld_ir  output  1  load instruction register
- ld_rf  output  1  load strobe to the instruction-field decode register
- pc_inc  output  1  PC += 1
- pc_ld  output  1  PC <= branch target
- alu_en  output  1  execute-stage enable
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request
- reg_we  output  1  register-file write enable
- halted  output  1  sequencer in HALT
- icount  output  CNT_W  retired-instruction count

Behaviour:
- States: HALT, P1, P2, P3, P4, P5 in a single state register.
- Outputs other than icount are decoded combinationally from the state, in_class, in_fcode, br_taken and mem_ready.
- Reset (asynchronous):
  - state=HALT, stop_pend=0, icount=0.
  - Therefore phase=0, all strobes 0, halted=1.
- HALT:
  - halted=1, all strobes 0.
  - start=1 and stop=0 -> P1.
  - start and stop in the same cycle -> remain HALT.
  - stop_pend is cleared while in HALT.
- P1 (fetch):
  - mem_rd=1.
  - If mem_ready=0: hold P1, ld_ir=0, pc_inc=0.
  - If mem_ready=1: ld_ir=1 and pc_inc=1 for that one cycle -> P2.
- P2 (decode):
  - ld_rf=1 for exactly one cycle -> P3.
  - in_class and in_fcode are valid from P3 onward.
- P3 (execute):
  - alu_en=1.
  - in_class=11 and in_fcode=HLT_FCODE -> HALT. The instruction is not counted and no register write occurs.
  - in_class=00 or 01 -> P4.
  - in_class=11 or 10 -> P5.
- P4 (memory):
  - in_class=00: mem_rd=1. in_class=01: mem_wr=1.
  - Hold P4 while mem_ready=0.
  - mem_ready=1 -> P5.
- P5 (writeback):
  - reg_we=1 for in_class 11 or 00.
  - pc_ld=1 when in_class=10 and br_taken=1.
  - icount increments by 1, wrapping modulo 2^CNT_W.
  - If stop_pend=1 or stop=1 this cycle -> HALT; else -> P1.
- stop handling:
  - A stop pulse in any state other than HALT sets sticky stop_pend.
  - The current instruction always completes through P5, except a halt instruction, which ends in P3.
- Exclusivity: exactly one phase bit is set outside HALT. mem_rd and mem_wr are never asserted together.
- start while not in HALT is ignored.
- Reset mid-instruction returns to HALT immediately and drops all strobes in the same cycle. No partial memory write may be assumed complete.

Test Plan:
- Reset then start, ALU instruction (class 11, fcode 0000), mem_ready tied 1 -> P1,P2,P3,P5 sequence; ld_ir/pc_inc in P1, ld_rf in P2, reg_we in P5; icount=1; back to P1.
- LD (class 00) with mem_ready low 2 cycles in P1 and 3 cycles in P4 -> P1 held 3 cycles and P4 held 4 cycles; mem_rd high throughout; ld_ir pulses only once; reg_we in P5.
- ST (class 01) -> mem_wr in P4 only, reg_we=0 in P5; branch (class 10) with br_taken=1 -> pc_ld=1 in P5; with br_taken=0 -> pc_ld=0.
- Halt instruction (class 11, fcode 1111) -> HALT straight after P3, halted=1, icount unchanged, no reg_we.
- stop pulse during P2 -> instruction completes P3..P5, icount increments, then HALT; start and stop in the same cycle while in HALT -> stays HALT.
- icount preloaded by running 65535 instructions then 1 more -> wraps to 0; rst asserted in P4 -> HALT, mem_rd/mem_wr drop in the same cycle, icount=0.
